// File: rtl/patbuf_pkg.sv
// Shared definitions for the pattern-buffer write path: buffer geometry,
// loader FSM states and the per-field offsets inside one pattern buffer.
package patbuf_pkg;

    localparam int BUFFER_SIZE  = 20;
    localparam int BUFFER_WIDTH = 8;
    localparam int ARM_TIMEOUT  = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_STREAM,
        ST_DRAIN
    } ld_state_e;

    // P group occupies offsets 0..9, N group mirrors it at 10..19.
    localparam logic [4:0] PDRIVE  = 5'd0;
    localparam logic [4:0] PCOMP   = 5'd1;
    localparam logic [4:0] PLEVEL  = 5'd2;
    localparam logic [4:0] PSLEW   = 5'd3;
    localparam logic [4:0] PTWEAK0 = 5'd4;
    localparam logic [4:0] PTWEAK1 = 5'd5;
    localparam logic [4:0] PTWEAK2 = 5'd6;
    localparam logic [4:0] PTWEAK3 = 5'd7;
    localparam logic [4:0] PTWEAK4 = 5'd8;
    localparam logic [4:0] PTWEAK5 = 5'd9;
    localparam logic [4:0] NDRIVE  = 5'd10;
    localparam logic [4:0] NCOMP   = 5'd11;
    localparam logic [4:0] NLEVEL  = 5'd12;
    localparam logic [4:0] NSLEW   = 5'd13;
    localparam logic [4:0] NTWEAK0 = 5'd14;
    localparam logic [4:0] NTWEAK1 = 5'd15;
    localparam logic [4:0] NTWEAK2 = 5'd16;
    localparam logic [4:0] NTWEAK3 = 5'd17;
    localparam logic [4:0] NTWEAK4 = 5'd18;
    localparam logic [4:0] NTWEAK5 = 5'd19;

    function automatic logic req_ok(
        input logic [4:0] field,
        input logic [4:0] count,
        input logic [5:0] size
    );
        logic [5:0] last;
        last = {1'b0, field} + {1'b0, count};
        return (count != 5'd0) && (last <= size);
    endfunction

endpackage

// File: rtl/patbuf_write_arbiter.sv
// Arbitrates the patternbuffer write port between the pat core and a bulk
// loader that streams a contiguous run of field bytes into one buffer.
module patbuf_write_arbiter
    import patbuf_pkg::*;
#(
    parameter int buffer_size  = BUFFER_SIZE,
    parameter int buffer_width = BUFFER_WIDTH,
    parameter int arm_timeout  = ARM_TIMEOUT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [2:0]              core_bufp,
    input  logic [4:0]              core_fieldp,
    input  logic [4:0]              core_fieldwp,
    input  logic [buffer_width-1:0] core_field_in,
    input  logic                    core_write,
    output logic                    core_stall,
    input  logic                    ld_start,
    input  logic [2:0]              ld_buf,
    input  logic [4:0]              ld_field,
    input  logic [4:0]              ld_count,
    input  logic [buffer_width-1:0] ld_data,
    input  logic                    ld_valid,
    output logic                    ld_ready,
    output logic                    ld_busy,
    output logic                    ld_done,
    output logic                    ld_err,
    output logic [2:0]              bufp_in,
    output logic [4:0]              fieldp_in,
    output logic [4:0]              fieldwp_in,
    output logic [buffer_width-1:0] field_in_in,
    output logic                    field_write_in
);

    localparam int ACW = (arm_timeout > 1) ? $clog2(arm_timeout) : 1;
    localparam logic [ACW-1:0] ARM_LAST = ACW'(arm_timeout - 1);
    localparam logic [5:0] SIZE6 = 6'(buffer_size);

    ld_state_e state_q, state_d;
    logic [2:0]     buf_q, buf_d;
    logic [4:0]     wptr_q, wptr_d;
    logic [4:0]     rem_q, rem_d;
    logic [ACW-1:0] arm_cnt_q, arm_cnt_d;

    logic [2:0]              bufp_q, bufp_d;
    logic [4:0]              fieldp_q, fieldp_d;
    logic [4:0]              fieldwp_q, fieldwp_d;
    logic [buffer_width-1:0] data_q, data_d;
    logic                    write_q, write_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;

    always_comb begin
        state_d   = state_q;
        buf_d     = buf_q;
        wptr_d    = wptr_q;
        rem_d     = rem_q;
        arm_cnt_d = arm_cnt_q;
        bufp_d    = core_bufp;
        fieldp_d  = core_fieldp;
        fieldwp_d = core_fieldwp;
        data_d    = core_field_in;
        write_d   = core_write;
        done_d    = 1'b0;
        err_d     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (ld_start) begin
                    if (req_ok(ld_field, ld_count, SIZE6)) begin
                        buf_d     = ld_buf;
                        wptr_d    = ld_field;
                        rem_d     = ld_count;
                        arm_cnt_d = '0;
                        state_d   = ST_ARM;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_ARM: begin
                // Wait for a quiet core cycle, but never longer than the timeout.
                if (!core_write || arm_cnt_q == ARM_LAST) begin
                    state_d = ST_STREAM;
                end else begin
                    arm_cnt_d = arm_cnt_q + 1'b1;
                end
            end
            ST_STREAM: begin
                bufp_d    = buf_q;
                fieldwp_d = wptr_q;
                data_d    = ld_data;
                write_d   = ld_valid;
                if (ld_valid) begin
                    rem_d = rem_q - 5'd1;
                    if (rem_q == 5'd1) begin
                        state_d = ST_DRAIN;
                    end else begin
                        wptr_d = wptr_q + 5'd1;
                    end
                end
            end
            ST_DRAIN: begin
                // Hold bufp one more cycle so it stays stable downstream.
                bufp_d    = buf_q;
                fieldwp_d = wptr_q;
                data_d    = '0;
                write_d   = 1'b0;
                done_d    = 1'b1;
                state_d   = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            buf_q     <= '0;
            wptr_q    <= '0;
            rem_q     <= '0;
            arm_cnt_q <= '0;
            bufp_q    <= '0;
            fieldp_q  <= '0;
            fieldwp_q <= '0;
            data_q    <= '0;
            write_q   <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            buf_q     <= buf_d;
            wptr_q    <= wptr_d;
            rem_q     <= rem_d;
            arm_cnt_q <= arm_cnt_d;
            bufp_q    <= bufp_d;
            fieldp_q  <= fieldp_d;
            fieldwp_q <= fieldwp_d;
            data_q    <= data_d;
            write_q   <= write_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign core_stall     = (state_q == ST_STREAM) || (state_q == ST_DRAIN);
    assign ld_ready       = (state_q == ST_STREAM);
    assign ld_busy        = (state_q != ST_IDLE);
    assign ld_done        = done_q;
    assign ld_err         = err_q;
    assign bufp_in        = bufp_q;
    assign fieldp_in      = fieldp_q;
    assign fieldwp_in     = fieldwp_q;
    assign field_in_in    = data_q;
    assign field_write_in = write_q;

endmodule

// File: doc/patbuf_write_arbiter.md
# patbuf_write_arbiter

Shares the pattern-buffer write port between the pat core and a bulk pattern loader. The block sits directly in front of `patternbuffer`, driving its `bufp_in`, `fieldp_in`, `fieldwp_in`, `field_in_in` and `field_write_in`. A load request streams a contiguous run of field bytes into one buffer through a valid/ready handshake, stalling core writes for the duration. The core read pointer (`fieldp_in`) always passes through and is never stalled.

## Interface
- `buffer_size`, 20, fields per buffer (field offsets 0–19: P group 0–9, N group 10–19)
- `buffer_width`, 8, field byte width
- `arm_timeout`, 4, maximum ARM cycles before the core is forcibly stalled
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `core_bufp`  in  3  core buffer pointer
- `core_fieldp`  in  5  core read field pointer
- `core_fieldwp`  in  5  core write field pointer
- `core_field_in`  in  8  core write data
- `core_write`  in  1  core write strobe
- `core_stall`  out  1  core write not forwarded; core holds its write until `core_stall` is 0
- `ld_start`  in  1  load request (single-cycle pulse)
- `ld_buf`  in  3  target buffer; sampled with `ld_start`
- `ld_field`  in  5  first field; sampled with `ld_start`
- `ld_count`  in  5  number of bytes (1..buffer_size); sampled with `ld_start`
- `ld_data`  in  8  stream byte
- `ld_valid`  in  1  `ld_data` valid
- `ld_ready`  out  1  block accepts a byte
- `ld_busy`  out  1  load in progress (ARM/STREAM/DRAIN)
- `ld_done`  out  1  one-cycle pulse when a load completes
- `ld_err`  out  1  one-cycle pulse when a request is rejected
- `bufp_in`, `fieldp_in`, `fieldwp_in`, `field_in_in`, `field_write_in`  out  3/5/5/8/1  to `patternbuffer`

## Operation
- **FSM states:** IDLE, ARM, STREAM, DRAIN.
- **IDLE.**
  - The core owns the port: outputs follow `core_*` (`field_write_in` = `core_write`).
  - On `ld_start`, the request is rejected if `ld_count` == 0 or `ld_field` + `ld_count` > `buffer_size` (6-bit sum). A rejected request pulses `ld_err` and stays in IDLE.
  - On a valid `ld_start`, the block latches `ld_buf`, `ld_field` (into write pointer `wptr`) and `ld_count` (into `remaining`), then goes to ARM. A `ld_start` seen outside IDLE is ignored.
- **ARM.**
  - The core still owns the port.
  - The block moves to STREAM on the first cycle where `core_write` == 0, or after `arm_timeout` ARM cycles, whichever comes first.
- **STREAM.**
  - `core_stall` = 1 and `ld_ready` = 1. `bufp_in` = latched buffer. `fieldp_in` still = `core_fieldp`.
  - On each `ld_valid` && `ld_ready` cycle: `field_write_in` = 1, `fieldwp_in` = `wptr`, `field_in_in` = `ld_data`, then `wptr`++ and `remaining`--.
  - Cycles without `ld_valid` produce `field_write_in` = 0 and no pointer change.
  - When the beat with `remaining` == 1 is accepted, the block goes to DRAIN.
- **DRAIN.**
  - One cycle with `ld_ready` = 0, `field_write_in` = 0, `bufp_in` still held and `core_stall` still 1. This keeps `bufp` stable through `patternbuffer`'s input register.
  - Then `ld_done` pulses and the FSM returns to IDLE; `core_stall` drops in the same cycle.
- **Pointer range:** `wptr` never exceeds `buffer_size`-1 (guaranteed by the request check); there is no wrap-around.

## Timing
- All outputs are registered.
- Core path latency: 1 cycle from `core_*` to the `patternbuffer` inputs, whose own register adds 1 more.
- `ld_ready`, `core_stall`, `ld_busy` and `ld_done` are decoded from registered state, so there is no combinational path from `ld_valid`.
- A stalled core write is dropped by this block; the core re-presents it after `core_stall` falls.
- **Reset values (asynchronous on `reset` low):** FSM = IDLE and every output = 0. If reset lands mid-load, the loader state is lost, no further writes are issued, and the target buffer contents are undefined.
- **Simultaneous `ld_start` and `core_write` in IDLE:** the core write is forwarded and ARM is entered.
- **Minimum load time:** `ld_count` + 3 cycles from `ld_start` to `ld_done`, with `core_write` low and `ld_valid` held high.

## Structure
- Shared package `patbuf_pkg` holds:
  - the FSM state enum;
  - `buffer_size` and `buffer_width`;
  - the field-offset constants PDRIVE=0 … PTWEAK5=9 and NDRIVE=10 … NTWEAK5=19, for reuse by `patternbuffer` and the loader software model.
- Single module, no sub-module; the expected size is about 180 lines.

## Test plan
- **Basic load.** Idle core, `ld_start` with `buf` = 3, `field` = 0, `count` = 20, bytes 0x00..0x13 with `ld_valid` held. Expect 20 writes to fieldwp 0..19 with `bufp_in` = 3. Expect `ld_done` at cycle 23. Read back via `core_fieldp` gives matching bytes.
- **Rejected requests.** (`field` = 15, `count` = 6) and (`count` = 0) each give a single `ld_err` pulse, no `field_write_in`, and `ld_busy` stays 0.
- **Arbitration.**
  - `core_write` high for 2 cycles after `ld_start`: STREAM is entered on the first low cycle and the core writes are forwarded unchanged.
  - `core_write` held high continuously: STREAM is forced after 4 ARM cycles and `core_stall` = 1.
- **Backpressure.** `ld_valid` toggles 1,0,0,1,1 with `count` = 3: exactly 3 writes at consecutive fieldwp, and gap cycles have `field_write_in` = 0.
- **Reset mid-stream.** `reset` low after 5 beats of a 10-byte load: all outputs 0 immediately. After release the FSM is in IDLE, `core_stall` = 0, and core writes are forwarded.
- **Read pointer passthrough.** `core_fieldp` sweeps 0..19 during STREAM and `fieldp_in` tracks it one cycle later.
